// File: rtl/hilo_muldiv_pkg.sv
// Shared ALU-op encodings used by the EX-stage multiply/divide unit.
// The ALU decoder drives these values on alucontrol.
package hilo_muldiv_pkg;

  localparam logic [7:0] ALU_MTHI  = 8'b0001_0001;
  localparam logic [7:0] ALU_MTLO  = 8'b0001_0011;
  localparam logic [7:0] ALU_MULT  = 8'b0001_1000;
  localparam logic [7:0] ALU_MULTU = 8'b0001_1001;
  localparam logic [7:0] ALU_DIV   = 8'b0001_1010;
  localparam logic [7:0] ALU_DIVU  = 8'b0001_1011;

  function automatic logic is_long_op(input logic [7:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_div.sv
// Iterative radix-2 restoring unsigned divider, one quotient bit per clock.
// quotient/remainder show the result of the step taken this cycle; they are final while done is high.
module div_radix2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [CW-1:0]     count;
  logic [DATA_W-1:0] q_p0, d_p0, r_p0;
  logic [DATA_W:0]   r_sh, diff;

  assign busy = (count != '0);
  assign done = (count == CW'(1));

  always_comb begin
    r_sh = {r_p0, q_p0[DATA_W-1]};
    diff = r_sh - {1'b0, d_p0};
    // A set top bit means the trial subtraction went negative: restore.
    if (!diff[DATA_W]) begin
      remainder = diff[DATA_W-1:0];
      quotient  = {q_p0[DATA_W-2:0], 1'b1};
    end else begin
      remainder = r_sh[DATA_W-1:0];
      quotient  = {q_p0[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        count <= '0;
    else if (start) count <= CW'(DATA_W);
    else if (busy)  count <= count - CW'(1);
  end

  // q_p0 starts as the dividend and is shifted out as quotient bits shift in.
  always_ff @(posedge clk) begin
    if (start) begin
      q_p0 <= dividend;
      d_p0 <= divisor;
      r_p0 <= '0;
    end else if (busy) begin
      q_p0 <= quotient;
      r_p0 <= remainder;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// EX-stage multiply/divide unit owning the architectural HI/LO pair.
// Stalls the pipeline while a MULT/DIV is in flight; MTHI/MTLO write with no stall.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        alucontrol_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              done_o
);

  localparam int CNT_MAX = (DATA_W > MUL_CYCLES) ? DATA_W : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic accept, is_mul, is_div, is_sgn, a_neg, b_neg, b_zero;
  logic mul_start, div_start, div_rst;

  assign accept    = (state == S_IDLE) && valid_i && !flush_i;
  assign is_mul    = (alucontrol_i == ALU_MULT) || (alucontrol_i == ALU_MULTU);
  assign is_div    = (alucontrol_i == ALU_DIV)  || (alucontrol_i == ALU_DIVU);
  assign is_sgn    = (alucontrol_i == ALU_MULT) || (alucontrol_i == ALU_DIV);
  assign a_neg     = is_sgn && a_i[DATA_W-1];
  assign b_neg     = is_sgn && b_i[DATA_W-1];
  assign b_zero    = (b_i == '0);
  assign mul_start = accept && is_mul;
  assign div_start = accept && is_div && !b_zero;
  assign div_rst   = rst || flush_i;

  // Stage p0: operands captured at acceptance, held for the whole operation
  logic signed [DATA_W:0]     ma_p0, mb_p0;
  logic                       qneg_p0, rneg_p0;
  logic signed [2*DATA_W-1:0] mx_p0, my_p0, prod_p0;

  always_ff @(posedge clk) begin
    if (mul_start) begin
      ma_p0 <= {a_neg, a_i};
      mb_p0 <= {b_neg, b_i};
    end
    if (div_start) begin
      qneg_p0 <= a_neg ^ b_neg;
      rneg_p0 <= a_neg;
    end
  end

  // The extension bit already encodes signed vs unsigned, so one signed product serves both.
  assign mx_p0   = {{(DATA_W-1){ma_p0[DATA_W]}}, ma_p0};
  assign my_p0   = {{(DATA_W-1){mb_p0[DATA_W]}}, mb_p0};
  assign prod_p0 = mx_p0 * my_p0;

  logic [DATA_W-1:0] div_q, div_r;
  logic              div_busy, div_done;

  div_radix2 #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (div_rst),
    .start     (div_start),
    .dividend  (neg_if(a_i, a_neg)),
    .divisor   (neg_if(b_i, b_neg)),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign stall_o = !flush_i &&
                   ((accept && is_long_op(alucontrol_i)) || (state == S_MUL) || div_busy);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hi_o   <= '0;
      lo_o   <= '0;
      done_o <= 1'b0;
    end else if (flush_i) begin
      state  <= S_IDLE;
      cnt    <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            if (is_mul) begin
              cnt   <= CNT_W'(MUL_CYCLES - 1);
              state <= S_MUL;
            end else if (is_div && b_zero) begin
              hi_o   <= a_i;
              lo_o   <= '1;
              state  <= S_DONE;
              done_o <= 1'b1;
            end else if (is_div) begin
              cnt   <= CNT_W'(DATA_W - 1);
              state <= S_DIV;
            end else if (alucontrol_i == ALU_MTHI) begin
              hi_o <= a_i;
            end else if (alucontrol_i == ALU_MTLO) begin
              lo_o <= a_i;
            end
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            {hi_o, lo_o} <= prod_p0;
            state        <= S_DONE;
            done_o       <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DIV: begin
          // div_done coincides with cnt reaching zero.
          if (div_done) begin
            lo_o   <= neg_if(div_q, qneg_p0);
            hi_o   <= neg_if(div_r, rneg_p0);
            state  <= S_DONE;
            done_o <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: directed ops push expected {HI,LO}, a monitor checks on done_o.
`timescale 1ns/1ps
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, valid, flush, stall, done;
  logic [7:0]   op;
  logic [W-1:0] a, b, hi, lo;

  logic         rst4, valid4, flush4, stall4, done4;
  logic [7:0]   op4;
  logic [W-1:0] a4, b4, hi4, lo4;

  hilo_muldiv #(.DATA_W(W), .MUL_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .alucontrol_i(op), .valid_i(valid), .a_i(a), .b_i(b),
    .flush_i(flush), .stall_o(stall), .hi_o(hi), .lo_o(lo), .done_o(done)
  );

  hilo_muldiv #(.DATA_W(W), .MUL_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .alucontrol_i(op4), .valid_i(valid4), .a_i(a4), .b_i(b4),
    .flush_i(flush4), .stall_o(stall4), .hi_o(hi4), .lo_o(lo4), .done_o(done4)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [2*W-1:0] sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done pulse with hi=%h lo=%h expected none", hi, lo);
      end else begin
        check("hilo_result", {hi, lo}, sb_q.pop_front());
      end
    end
  end

  // Holds the instruction in EX while stalled, like the pipeline would, and counts stall cycles.
  task automatic run_op(input string name, input logic [7:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [63:0] exp, input int exp_stall);
    int st;
    bit ok;
    st = 0;
    ok = 0;
    sb_q.push_back(exp);
    @(negedge clk);
    op = o; a = x; b = y; valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stall) begin
        ok = 1;
        break;
      end
      st++;
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: stall still high after %0d cycles expected release", name, st);
    end
    check({name, "_stall"}, 64'(st), 64'(exp_stall));
    @(negedge clk);
    valid = 1'b0;
    op = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    rst = 1'b1; valid = 1'b0; flush = 1'b0; op = 8'h00; a = '0; b = '0;
    rst4 = 1'b1; valid4 = 1'b0; flush4 = 1'b0; op4 = 8'h00; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst4 = 1'b0;
    #1;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_stall", 64'(stall), 64'h0);
    check("reset_done", 64'(done), 64'h0);

    run_op("mult_neg",    ALU_MULT,  32'hFFFFFFFD, 32'd7,        {32'hFFFFFFFF, 32'hFFFFFFEB}, 2);
    run_op("multu_max",   ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, 2);
    run_op("mult_minmin", ALU_MULT,  32'h80000000, 32'h80000000, {32'h40000000, 32'h00000000}, 2);
    run_op("div_neg",     ALU_DIV,   32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    run_op("divu_big",    ALU_DIVU,  32'h80000000, 32'd3,        {32'h00000002, 32'h2AAAAAAA}, 33);
    run_op("div_ovf",     ALU_DIV,   32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 33);
    run_op("div_negdiv",  ALU_DIV,   32'd7,        32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33);
    run_op("div_zero",    ALU_DIV,   32'd5,        32'd0,        {32'h00000005, 32'hFFFFFFFF}, 1);

    // Flush in the 10th stall cycle of a divide: no result, HI/LO untouched.
    @(negedge clk);
    op = ALU_DIV; a = 32'd100; b = 32'd7; valid = 1'b1;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall_low", 64'(stall), 64'h0);
    @(negedge clk);
    flush = 1'b0; valid = 1'b0; op = 8'h00;
    #1;
    check("after_flush_stall", 64'(stall), 64'h0);
    check("after_flush_hi", 64'(hi), 64'h5);
    check("after_flush_lo", 64'(lo), 64'hFFFFFFFF);

    // MTHI coinciding with a flush is dropped.
    @(negedge clk);
    op = ALU_MTHI; a = 32'hDEAD; valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    #1;
    check("mthi_flushed", 64'(hi), 64'h5);

    @(negedge clk);
    op = ALU_MTHI; a = 32'h1234; valid = 1'b1;
    #1;
    check("mthi_stall", 64'(stall), 64'h0);
    @(negedge clk);
    op = ALU_MTLO; a = 32'hABCD;
    #1;
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mtlo_stall", 64'(stall), 64'h0);
    @(negedge clk);
    valid = 1'b0; op = 8'h00;
    #1;
    check("mtlo_lo", 64'(lo), 64'hABCD);
    check("mthi_hi_kept", 64'(hi), 64'h1234);

    // The divider must restart cleanly after the aborted operation.
    run_op("div_after_flush", ALU_DIV, 32'd100, 32'd7, {32'h00000002, 32'h0000000E}, 33);

    // MUL_CYCLES = 4: full multiply, then reset part-way through a second one.
    @(negedge clk);
    op4 = ALU_MULT; a4 = 32'd3; b4 = 32'hFFFFFFFB; valid4 = 1'b1;
    st = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!stall4) break;
      st++;
      @(negedge clk);
    end
    check("mul4_stall", 64'(st), 64'd5);
    check("mul4_done", 64'(done4), 64'h1);
    check("mul4_result", {hi4, lo4}, {32'hFFFFFFFF, 32'hFFFFFFF1});
    @(negedge clk);
    op4 = ALU_MULT; a4 = 32'd6; b4 = 32'd7;
    repeat (2) @(negedge clk);
    rst4 = 1'b1; valid4 = 1'b0; op4 = 8'h00;
    @(negedge clk);
    rst4 = 1'b0;
    #1;
    check("rst4_hi", 64'(hi4), 64'h0);
    check("rst4_lo", 64'(lo4), 64'h0);
    check("rst4_stall", 64'(stall4), 64'h0);
    check("rst4_done", 64'(done4), 64'h0);
    repeat (6) @(negedge clk);
    #1;
    check("rst4_no_late_result", {hi4, lo4}, 64'h0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
